decode_check_monitor: RTL and testbench
=======================================

// Module: decode_check_monitor
// PURPOSE
//  Cycle-accurate checker for the decoder's scoreboard output, N issue lanes.
//  - Taps each lane's raw instruction and the decoded entry (rs1/rs2/rd/op/fu).
//  - Computes the expected decode and delays it by the decoder's pipeline latency.
//  - Compares expected against actual; counts checks and mismatches; captures the first failure.
//  - Bound beside the decoder in the formal/sim TB; also usable as a synthesizable on-chip monitor.
// PARAMETERS
//  NUM_LANES  2   issue lanes checked in parallel (1..4)
//  LATENCY    1   cycles from instr_i to decoded fields (0..4)
//  REG_W      6   register-address width (ariane REG_ADDR_SIZE)
//  OP_W       7   fu_op encoding width (ariane_pkg fu_op_t)
//  FU_W       4   fu_t encoding width (ariane_pkg fu_t)
//  CNT_W      16  check/mismatch counter width
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous, active-high reset
//  valid_i        in   NUM_LANES       lane carries an instruction this cycle
//  instr_i        in   NUM_LANES*32    uncompressed instruction per lane
//  rs1_i,rs2_i    in   NUM_LANES*REG_W decoder rs1/rs2, sampled LATENCY cycles after instr_i
//  rd_i           in   NUM_LANES*REG_W decoder rd, same timing
//  op_i           in   NUM_LANES*OP_W  decoder op, same timing
//  fu_i           in   NUM_LANES*FU_W  decoder fu, same timing
//  flush_i        in   1               kill all in-flight expected entries
//  clear_i        in   1               zero counters, sticky error and capture
//  check_cnt_o    out  CNT_W           lanes compared, saturating
//  mismatch_cnt_o out  CNT_W           lanes failed, saturating
//  error_o        out  1               sticky: at least one mismatch
//  fail_lane_o    out  2               lane of the first mismatch
//  fail_instr_o   out  32              instruction of the first mismatch
//  fail_mask_o    out  5               bit 0 rs1, 1 rs2, 2 rd, 3 op, 4 fu
// BEHAVIOUR
//  Reset and outputs
//  - All outputs and pipeline valids are 0 one cycle after reset is sampled high.
//  - Reset mid-operation discards in-flight entries; no check fires for them.
//  Expected-decode rules (opcode instr[6:0])
//  - Unlisted opcode: entry marked "unchecked"; never compared or counted.
//  - 0110011 OP: funct7 00/20/01 x funct3 -> ADD,SUB,SLL,SLTS,SLTU,XORL,SRL,SRA,ORL,ANDL / MUL..REMU.
//    fu = ALU or MULT; rs1, rs2 and rd are all checked.
//  - 0011011 OP-IMM-32: f3=000 ADDW, 001 SLLW, 101 SRLW/SRAW by instr[30]; fu ALU; rs2 not checked.
//  - 0000011 LOAD: f3 -> LB,LH,LW,LD,LBU,LHU,LWU; fu LOAD; rs2 not checked.
//  - 0100011 STORE: f3 000..011 -> SB,SH,SW,SD; fu STORE; rd not checked.
//  - rs fields are zero-extended from 5 to REG_W bits.
//  - Illegal funct combination within a listed opcode: treated as unchecked.
//  Pipeline
//  - Per-lane shift register, LATENCY deep: valid, checked flag, expected fields, instr.
//  - LATENCY=0 compares combinationally in the same cycle; counters update on the next edge.
//  - flush_i zeroes every stage valid.
//    Same-cycle valid_i is also dropped when LATENCY>0; with LATENCY=0 it is still checked.
//  Compare and count
//  - A lane is compared when its delayed entry is valid and checked.
//  - Mismatch = any checked field differs; fail_mask_o reports which fields.
//  - check_cnt_o += lanes compared; mismatch_cnt_o += popcount of failing lanes.
//  - Both counters saturate at all-ones and never wrap.
//  - First mismatch sets error_o and latches fail_*; later mismatches do not overwrite.
//  - Several lanes failing in the same cycle: lowest lane index is captured.
//  - clear_i has priority over same-cycle increments and captures; the next cycle counts normally.
// CONFIGURATION
//  DECODE_CHK_SVA_EN defined:
//  - Adds one concurrent assertion per lane: a compared lane must have zero mismatch.
//  - Adds an assume that valid_i is 0 while reset is high.
//  - Counters and outputs are unchanged.
//  DECODE_CHK_SVA_EN undefined: no SVA; pure synthesizable RTL.
// TESTING
//  1. LATENCY=1, lane0 0x002081B3, next cycle rs1=1 rs2=2 rd=3 op=ADD fu=ALU
//     -> check_cnt=1, mismatch_cnt=0, error=0.
//  2. Lane1 0x402081B3 with op=ADD returned
//     -> mismatch_cnt=1, error=1, fail_lane=1, fail_instr=0x402081B3, fail_mask=5'b01000.
//  3. Lane0 0x00853283 (LD x5,8(x10)), rs1=10 rd=5 op=LD fu=LOAD, rs2 driven 7
//     -> pass: rs2 ignored for loads.
//  4. Both lanes fail in one cycle
//     -> mismatch_cnt += 2; fail_lane=0 captured; a later failure on lane1 leaves capture unchanged.
//  5. LATENCY=3: issue 3 instrs, assert flush_i in cycle 2
//     -> no compares occur, check_cnt unchanged; reset mid-stream also yields no compares.
//  6. CNT_W=4: 20 back-to-back mismatches -> mismatch_cnt=15 held.
//     clear_i -> all counters, error and capture read 0 next cycle.

Source files
------------

// File: rtl/decode_check_if.sv
// Lane taps between the decoder and decode_check_monitor: the raw instruction
// per lane plus the decoded scoreboard fields returned LATENCY cycles later.
interface decode_check_if #(
    parameter int NUM_LANES = 2,
    parameter int REG_W     = 6,
    parameter int OP_W      = 7,
    parameter int FU_W      = 4
);
    logic [NUM_LANES-1:0]       valid_i;
    logic [NUM_LANES*32-1:0]    instr_i;
    logic [NUM_LANES*REG_W-1:0] rs1_i;
    logic [NUM_LANES*REG_W-1:0] rs2_i;
    logic [NUM_LANES*REG_W-1:0] rd_i;
    logic [NUM_LANES*OP_W-1:0]  op_i;
    logic [NUM_LANES*FU_W-1:0]  fu_i;

    modport master (
        output valid_i, instr_i, rs1_i, rs2_i, rd_i, op_i, fu_i
    );

    modport slave (
        input valid_i, instr_i, rs1_i, rs2_i, rd_i, op_i, fu_i
    );
endinterface

// File: rtl/decode_check_monitor.sv
// decode_check_monitor: re-decodes each lane's instruction, delays the expected
// entry by the decoder latency and compares it against the decoder's output.
// Counts compared and failing lanes (saturating) and captures the first failure.
// Optional: define DECODE_CHK_SVA_EN to bind per-lane SVA checks (no effect on outputs).
// op encodings: ADD 0 SUB 1 SLL 2 SLTS 3 SLTU 4 XORL 5 SRL 6 SRA 7 ORL 8 ANDL 9
//   MUL 10 MULH 11 MULHSU 12 MULHU 13 DIV 14 DIVU 15 REM 16 REMU 17
//   ADDW 18 SLLW 19 SRLW 20 SRAW 21 LB 22 LH 23 LW 24 LD 25 LBU 26 LHU 27 LWU 28
//   SB 29 SH 30 SW 31 SD 32;  fu encodings: LOAD 1 STORE 2 ALU 3 MULT 5.

`ifdef DECODE_CHK_SVA_EN
// Property checks kept apart from the monitor datapath.
module decode_check_sva #(
    parameter int NUM_LANES = 2
) (
    input logic                 clk,
    input logic                 reset,
    input logic [NUM_LANES-1:0] valid,
    input logic [NUM_LANES-1:0] cmp,
    input logic [NUM_LANES-1:0] fail
);
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        a_no_mismatch: assert property (@(posedge clk) disable iff (reset) cmp[l] |-> !fail[l]);
    end
    a_reset_quiet: assume property (@(posedge clk) reset |-> (valid == '0));
endmodule
`endif

module decode_check_monitor #(
    parameter int NUM_LANES = 2,
    parameter int LATENCY   = 1,
    parameter int REG_W     = 6,
    parameter int OP_W      = 7,
    parameter int FU_W      = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    decode_check_if.slave    dec,
    input  logic             flush_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] check_cnt_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic             error_o,
    output logic [1:0]       fail_lane_o,
    output logic [31:0]      fail_instr_o,
    output logic [4:0]       fail_mask_o
);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(7'd0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(7'd1);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(7'd2);
    localparam logic [OP_W-1:0] OP_SLTS = OP_W'(7'd3);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7'd4);
    localparam logic [OP_W-1:0] OP_XORL = OP_W'(7'd5);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7'd6);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7'd7);
    localparam logic [OP_W-1:0] OP_ORL  = OP_W'(7'd8);
    localparam logic [OP_W-1:0] OP_ANDL = OP_W'(7'd9);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(7'd10);
    localparam logic [OP_W-1:0] OP_ADDW = OP_W'(7'd18);
    localparam logic [OP_W-1:0] OP_SLLW = OP_W'(7'd19);
    localparam logic [OP_W-1:0] OP_SRLW = OP_W'(7'd20);
    localparam logic [OP_W-1:0] OP_SRAW = OP_W'(7'd21);
    localparam logic [OP_W-1:0] OP_LB   = OP_W'(7'd22);
    localparam logic [OP_W-1:0] OP_SB   = OP_W'(7'd29);

    localparam logic [FU_W-1:0] FU_LOAD  = FU_W'(4'd1);
    localparam logic [FU_W-1:0] FU_STORE = FU_W'(4'd2);
    localparam logic [FU_W-1:0] FU_ALU   = FU_W'(4'd3);
    localparam logic [FU_W-1:0] FU_MULT  = FU_W'(4'd5);

    // en: per-field compare enable, bit 0 rs1, 1 rs2, 2 rd, 3 op, 4 fu
    typedef struct packed {
        logic            vld;
        logic            chk;
        logic [4:0]      en;
        logic [31:0]     instr;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [OP_W-1:0] op;
        logic [FU_W-1:0] fu;
    } ent_t;

    // Expected decode of one instruction; chk stays 0 for anything not modelled.
    function automatic ent_t decode_f(input logic [31:0] ins);
        ent_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        e       = '0;
        f3      = ins[14:12];
        f7      = ins[31:25];
        e.instr = ins;
        e.rs1   = REG_W'(ins[19:15]);
        e.rs2   = REG_W'(ins[24:20]);
        e.rd    = REG_W'(ins[11:7]);
        case (ins[6:0])
            7'b0110011: begin
                e.chk = 1'b1;
                e.en  = 5'b11111;
                e.fu  = (f7 == 7'h01) ? FU_MULT : FU_ALU;
                case ({f7, f3})
                    {7'h00, 3'd0}: e.op = OP_ADD;
                    {7'h20, 3'd0}: e.op = OP_SUB;
                    {7'h00, 3'd1}: e.op = OP_SLL;
                    {7'h00, 3'd2}: e.op = OP_SLTS;
                    {7'h00, 3'd3}: e.op = OP_SLTU;
                    {7'h00, 3'd4}: e.op = OP_XORL;
                    {7'h00, 3'd5}: e.op = OP_SRL;
                    {7'h20, 3'd5}: e.op = OP_SRA;
                    {7'h00, 3'd6}: e.op = OP_ORL;
                    {7'h00, 3'd7}: e.op = OP_ANDL;
                    {7'h01, 3'd0}, {7'h01, 3'd1}, {7'h01, 3'd2}, {7'h01, 3'd3},
                    {7'h01, 3'd4}, {7'h01, 3'd5}, {7'h01, 3'd6}, {7'h01, 3'd7}:
                        e.op = OP_MUL + OP_W'(f3);
                    default: e.chk = 1'b0;
                endcase
            end
            7'b0011011: begin
                e.chk = 1'b1;
                e.en  = 5'b11101;
                e.fu  = FU_ALU;
                case (f3)
                    3'd0:    e.op = OP_ADDW;
                    3'd1:    e.op = OP_SLLW;
                    3'd5:    e.op = ins[30] ? OP_SRAW : OP_SRLW;
                    default: e.chk = 1'b0;
                endcase
            end
            7'b0000011: begin
                e.en  = 5'b11101;
                e.fu  = FU_LOAD;
                e.chk = (f3 != 3'd7);
                e.op  = OP_LB + OP_W'(f3);
            end
            7'b0100011: begin
                e.en  = 5'b11011;
                e.fu  = FU_STORE;
                e.chk = ~f3[2];
                e.op  = OP_SB + OP_W'(f3[1:0]);
            end
            default: e.chk = 1'b0;
        endcase
        return e;
    endfunction

    // Saturating add of up to four lane hits.
    function automatic logic [CNT_W-1:0] sat_add_f(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W+2:0] s;
        s = {3'b000, a} + {{CNT_W{1'b0}}, b};
        return (|s[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    ent_t                  cur_s [NUM_LANES];
    ent_t                  dly_s [NUM_LANES];
    logic [NUM_LANES-1:0]  cmp_s;
    logic [NUM_LANES-1:0]  fail_s;
    logic [4:0]            lane_mask_s [NUM_LANES];
    logic [2:0]            cmp_sum_s;
    logic [2:0]            fail_sum_s;
    logic [1:0]            sel_lane_s;
    logic [31:0]           sel_instr_s;
    logic [4:0]            sel_mask_s;

    logic [CNT_W-1:0]      check_cnt_r;
    logic [CNT_W-1:0]      mismatch_cnt_r;
    logic                  error_r;
    logic [1:0]            fail_lane_r;
    logic [31:0]           fail_instr_r;
    logic [4:0]            fail_mask_r;

    // Expected entry for every lane in the issue cycle.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            cur_s[l]     = decode_f(dec.instr_i[l*32 +: 32]);
            cur_s[l].vld = dec.valid_i[l];
        end
    end

    if (LATENCY == 0) begin : g_lat0
        // No pipeline: compare in the issue cycle, flush does not apply.
        always_comb dly_s = cur_s;
    end else begin : g_pipe
        ent_t pipe_r [NUM_LANES][LATENCY];

        // Shift expected entries; reset and flush kill every stage including the incoming one.
        always_ff @(posedge clk) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                pipe_r[l][0] <= cur_s[l];
                for (int s = 1; s < LATENCY; s++) begin
                    pipe_r[l][s] <= pipe_r[l][s-1];
                end
                if (reset || flush_i) begin
                    for (int s = 0; s < LATENCY; s++) begin
                        pipe_r[l][s].vld <= 1'b0;
                    end
                end
            end
        end

        // Oldest stage lines up with the decoder output.
        always_comb begin
            for (int l = 0; l < NUM_LANES; l++) begin
                dly_s[l] = pipe_r[l][LATENCY-1];
            end
        end
    end

    // Per-lane field compare and reduction to counts and the lowest failing lane.
    always_comb begin
        cmp_sum_s   = 3'd0;
        fail_sum_s  = 3'd0;
        sel_lane_s  = 2'd0;
        sel_instr_s = 32'd0;
        sel_mask_s  = 5'd0;
        for (int l = 0; l < NUM_LANES; l++) begin
            cmp_s[l] = dly_s[l].vld & dly_s[l].chk;
            lane_mask_s[l] = cmp_s[l] ? (dly_s[l].en & {
                dec.fu_i[l*FU_W +: FU_W]    != dly_s[l].fu,
                dec.op_i[l*OP_W +: OP_W]    != dly_s[l].op,
                dec.rd_i[l*REG_W +: REG_W]  != dly_s[l].rd,
                dec.rs2_i[l*REG_W +: REG_W] != dly_s[l].rs2,
                dec.rs1_i[l*REG_W +: REG_W] != dly_s[l].rs1}) : 5'b00000;
            fail_s[l]  = |lane_mask_s[l];
            cmp_sum_s  = cmp_sum_s + {2'b00, cmp_s[l]};
            fail_sum_s = fail_sum_s + {2'b00, fail_s[l]};
        end
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            sel_lane_s  = fail_s[l] ? 2'(l) : sel_lane_s;
            sel_instr_s = fail_s[l] ? dly_s[l].instr : sel_instr_s;
            sel_mask_s  = fail_s[l] ? lane_mask_s[l] : sel_mask_s;
        end
    end

    // Counters and first-failure capture; clear overrides same-cycle updates.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            check_cnt_r    <= {CNT_W{1'b0}};
            mismatch_cnt_r <= {CNT_W{1'b0}};
            error_r        <= 1'b0;
            fail_lane_r    <= 2'd0;
            fail_instr_r   <= 32'd0;
            fail_mask_r    <= 5'd0;
        end else begin
            check_cnt_r    <= sat_add_f(check_cnt_r, cmp_sum_s);
            mismatch_cnt_r <= sat_add_f(mismatch_cnt_r, fail_sum_s);
            if ((|fail_s) && !error_r) begin
                error_r      <= 1'b1;
                fail_lane_r  <= sel_lane_s;
                fail_instr_r <= sel_instr_s;
                fail_mask_r  <= sel_mask_s;
            end
        end
    end

    assign check_cnt_o    = check_cnt_r;
    assign mismatch_cnt_o = mismatch_cnt_r;
    assign error_o        = error_r;
    assign fail_lane_o    = fail_lane_r;
    assign fail_instr_o   = fail_instr_r;
    assign fail_mask_o    = fail_mask_r;

`ifdef DECODE_CHK_SVA_EN
    decode_check_sva #(.NUM_LANES(NUM_LANES)) u_sva (
        .clk   (clk),
        .reset (reset),
        .valid (dec.valid_i),
        .cmp   (cmp_s),
        .fail  (fail_s)
    );
`endif
endmodule

// File: tb/tb_decode_check_monitor.sv
// Directed bench for decode_check_monitor: table of LATENCY=1 transactions plus
// hand sequences for flush/reset (LATENCY=3), same-cycle compare (LATENCY=0)
// and counter saturation / clear (CNT_W=4).
module tb_decode_check_monitor;
    localparam logic [6:0] OP_ADD = 7'd0,  OP_MUL = 7'd10, OP_SRAW = 7'd21;
    localparam logic [6:0] OP_LW  = 7'd24, OP_LD  = 7'd25, OP_SD   = 7'd32;
    localparam logic [3:0] FU_LOAD = 4'd1, FU_STORE = 4'd2, FU_ALU = 4'd3, FU_MULT = 4'd5;

    typedef struct {
        logic            clr;
        logic [1:0]      valid;
        logic [1:0][31:0] instr;
        logic [1:0][5:0] rs1;
        logic [1:0][5:0] rs2;
        logic [1:0][5:0] rd;
        logic [1:0][6:0] op;
        logic [1:0][3:0] fu;
        logic [15:0]     ecnt;
        logic [15:0]     emis;
        logic            eerr;
        logic [1:0]      elane;
        logic [31:0]     einstr;
        logic [4:0]      emask;
    } vec_t;

    logic clk = 1'b0;
    logic rst1, rst3, rst0, rst4;
    logic flush1, flush3, flush0, flush4;
    logic clear1, clear3, clear0, clear4;
    int   n_chk = 0;
    int   n_err = 0;

    logic [15:0] cnt1, mis1, cnt3, mis3, cnt0, mis0;
    logic [3:0]  cnt4, mis4;
    logic        err1, err3, err0, err4;
    logic [1:0]  lane1, lane3, lane0, lane4;
    logic [31:0] ins1, ins3, ins0, ins4;
    logic [4:0]  msk1, msk3, msk0, msk4;

    decode_check_if #(.NUM_LANES(2), .REG_W(6), .OP_W(7), .FU_W(4)) bus ();

    always #5 clk = ~clk;

    decode_check_monitor #(.NUM_LANES(2), .LATENCY(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(rst1), .dec(bus.slave), .flush_i(flush1), .clear_i(clear1),
        .check_cnt_o(cnt1), .mismatch_cnt_o(mis1), .error_o(err1),
        .fail_lane_o(lane1), .fail_instr_o(ins1), .fail_mask_o(msk1));

    decode_check_monitor #(.NUM_LANES(2), .LATENCY(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset(rst3), .dec(bus.slave), .flush_i(flush3), .clear_i(clear3),
        .check_cnt_o(cnt3), .mismatch_cnt_o(mis3), .error_o(err3),
        .fail_lane_o(lane3), .fail_instr_o(ins3), .fail_mask_o(msk3));

    decode_check_monitor #(.NUM_LANES(2), .LATENCY(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(rst0), .dec(bus.slave), .flush_i(flush0), .clear_i(clear0),
        .check_cnt_o(cnt0), .mismatch_cnt_o(mis0), .error_o(err0),
        .fail_lane_o(lane0), .fail_instr_o(ins0), .fail_mask_o(msk0));

    decode_check_monitor #(.NUM_LANES(2), .LATENCY(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(rst4), .dec(bus.slave), .flush_i(flush4), .clear_i(clear4),
        .check_cnt_o(cnt4), .mismatch_cnt_o(mis4), .error_o(err4),
        .fail_lane_o(lane4), .fail_instr_o(ins4), .fail_mask_o(msk4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Lane0 carries a correct ADD x3,x1,x2 decode; lane1 idle.
    task automatic drive_add_fields();
        bus.rs1_i = {6'd0, 6'd1};
        bus.rs2_i = {6'd0, 6'd2};
        bus.rd_i  = {6'd0, 6'd3};
        bus.op_i  = {7'd0, OP_ADD};
        bus.fu_i  = {4'd0, FU_ALU};
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b0, 2'b01, {32'h0, 32'h002081B3}, {6'd0, 6'd1}, {6'd0, 6'd2}, {6'd0, 6'd3},
                    {7'd0, OP_ADD}, {4'd0, FU_ALU}, 16'd1, 16'd0, 1'b0, 2'd0, 32'h0, 5'b00000};
        vecs[1] = '{1'b0, 2'b10, {32'h402081B3, 32'h0}, {6'd1, 6'd0}, {6'd2, 6'd0}, {6'd3, 6'd0},
                    {OP_ADD, 7'd0}, {FU_ALU, 4'd0}, 16'd2, 16'd1, 1'b1, 2'd1, 32'h402081B3, 5'b01000};
        vecs[2] = '{1'b0, 2'b01, {32'h0, 32'h00853283}, {6'd0, 6'd10}, {6'd0, 6'd7}, {6'd0, 6'd5},
                    {7'd0, OP_LD}, {4'd0, FU_LOAD}, 16'd3, 16'd1, 1'b1, 2'd1, 32'h402081B3, 5'b01000};
        vecs[3] = '{1'b0, 2'b11, {32'h00000013, 32'h00B53423}, {6'd9, 6'd10}, {6'd9, 6'd11}, {6'd9, 6'd63},
                    {7'd5, OP_SD}, {4'd7, FU_STORE}, 16'd4, 16'd1, 1'b1, 2'd1, 32'h402081B3, 5'b01000};
        vecs[4] = '{1'b0, 2'b11, {32'h4030D19B, 32'h402091B3}, {6'd1, 6'd0}, {6'd9, 6'd0}, {6'd3, 6'd0},
                    {OP_SRAW, 7'd0}, {FU_ALU, 4'd0}, 16'd5, 16'd1, 1'b1, 2'd1, 32'h402081B3, 5'b01000};
        vecs[5] = '{1'b1, 2'b01, {32'h0, 32'h002081B3}, {6'd0, 6'd1}, {6'd0, 6'd2}, {6'd0, 6'd4},
                    {7'd0, OP_ADD}, {4'd0, FU_ALU}, 16'd0, 16'd0, 1'b0, 2'd0, 32'h0, 5'b00000};
        vecs[6] = '{1'b0, 2'b01, {32'h0, 32'h022081B3}, {6'd0, 6'd1}, {6'd0, 6'd2}, {6'd0, 6'd3},
                    {7'd0, OP_MUL}, {4'd0, FU_MULT}, 16'd1, 16'd0, 1'b0, 2'd0, 32'h0, 5'b00000};
        vecs[7] = '{1'b0, 2'b11, {32'h402081B3, 32'h002081B3}, {6'd1, 6'd1}, {6'd2, 6'd2}, {6'd3, 6'd4},
                    {OP_ADD, OP_ADD}, {FU_ALU, FU_ALU}, 16'd3, 16'd2, 1'b1, 2'd0, 32'h002081B3, 5'b00100};
        vecs[8] = '{1'b0, 2'b10, {32'h402081B3, 32'h0}, {6'd1, 6'd0}, {6'd2, 6'd0}, {6'd3, 6'd0},
                    {OP_ADD, 7'd0}, {FU_ALU, 4'd0}, 16'd4, 16'd3, 1'b1, 2'd0, 32'h002081B3, 5'b00100};
        vecs[9] = '{1'b0, 2'b01, {32'h0, 32'h00852283}, {6'd0, 6'd11}, {6'd0, 6'd0}, {6'd0, 6'd5},
                    {7'd0, OP_LW}, {4'd0, FU_ALU}, 16'd5, 16'd4, 1'b1, 2'd0, 32'h002081B3, 5'b00100};

        rst1 = 1'b1; rst3 = 1'b1; rst0 = 1'b1; rst4 = 1'b1;
        flush1 = 1'b0; flush3 = 1'b0; flush0 = 1'b0; flush4 = 1'b0;
        clear1 = 1'b0; clear3 = 1'b0; clear0 = 1'b0; clear4 = 1'b0;
        bus.valid_i = 2'b00;
        bus.instr_i = 64'd0;
        bus.rs1_i = 12'd0; bus.rs2_i = 12'd0; bus.rd_i = 12'd0;
        bus.op_i = 14'd0; bus.fu_i = 8'd0;
        step();
        step();

        // Reset state
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_mis", 32'(mis1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_lane", 32'(lane1), 32'd0);
        chk("rst_instr", ins1, 32'd0);
        chk("rst_mask", 32'(msk1), 32'd0);
        chk("rst_cnt3", 32'(cnt3), 32'd0);
        chk("rst_cnt4", 32'(cnt4), 32'd0);

        // LATENCY=1 table: issue cycle, then return cycle, then check.
        rst1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.valid_i = vecs[i].valid;
            bus.instr_i = vecs[i].instr;
            clear1 = 1'b0;
            step();
            bus.valid_i = 2'b00;
            bus.rs1_i = vecs[i].rs1;
            bus.rs2_i = vecs[i].rs2;
            bus.rd_i  = vecs[i].rd;
            bus.op_i  = vecs[i].op;
            bus.fu_i  = vecs[i].fu;
            clear1 = vecs[i].clr;
            step();
            clear1 = 1'b0;
            chk($sformatf("v%0d_cnt", i), 32'(cnt1), 32'(vecs[i].ecnt));
            chk($sformatf("v%0d_mis", i), 32'(mis1), 32'(vecs[i].emis));
            chk($sformatf("v%0d_err", i), 32'(err1), 32'(vecs[i].eerr));
            chk($sformatf("v%0d_lane", i), 32'(lane1), 32'(vecs[i].elane));
            chk($sformatf("v%0d_instr", i), ins1, vecs[i].einstr);
            chk($sformatf("v%0d_mask", i), 32'(msk1), 32'(vecs[i].emask));
        end

        // LATENCY=3: one normal compare, then flushed and reset-killed streams.
        bus.valid_i = 2'b00;
        bus.instr_i = {32'h0, 32'h002081B3};
        drive_add_fields();
        rst3 = 1'b0;
        bus.valid_i = 2'b01;
        step();
        bus.valid_i = 2'b00;
        step(); step();
        chk("l3_early", 32'(cnt3), 32'd0);
        step();
        chk("l3_cnt", 32'(cnt3), 32'd1);
        chk("l3_mis", 32'(mis3), 32'd0);
        bus.valid_i = 2'b01;
        step(); step();
        flush3 = 1'b1;
        step();
        flush3 = 1'b0;
        bus.valid_i = 2'b00;
        for (int i = 0; i < 5; i++) step();
        chk("l3_flush_cnt", 32'(cnt3), 32'd1);
        bus.valid_i = 2'b01;
        step(); step(); step();
        bus.valid_i = 2'b00;
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("l3_rst_cnt", 32'(cnt3), 32'd0);
        chk("l3_rst_err", 32'(err3), 32'd0);

        // LATENCY=0: same-cycle compare, still checked under flush.
        rst0 = 1'b0;
        step();
        bus.valid_i = 2'b01;
        bus.instr_i = {32'h0, 32'h002081B3};
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        bus.valid_i = 2'b00;
        chk("l0_cnt", 32'(cnt0), 32'd1);
        chk("l0_mis", 32'(mis0), 32'd0);
        bus.valid_i = 2'b01;
        bus.instr_i = {32'h0, 32'h402081B3};
        step();
        bus.valid_i = 2'b00;
        chk("l0_mis2", 32'(mis0), 32'd1);
        chk("l0_mask", 32'(msk0), 32'(5'b01000));

        // CNT_W=4: 20 back-to-back mismatches saturate at 15, then clear.
        rst4 = 1'b0;
        step();
        bus.instr_i = {32'h0, 32'h402081B3};
        for (int i = 0; i < 20; i++) begin
            bus.valid_i = 2'b01;
            step();
        end
        bus.valid_i = 2'b00;
        step();
        chk("sat_mis", 32'(mis4), 32'd15);
        chk("sat_cnt", 32'(cnt4), 32'd15);
        chk("sat_err", 32'(err4), 32'd1);
        chk("sat_instr", ins4, 32'h402081B3);
        chk("sat_mask", 32'(msk4), 32'(5'b01000));
        clear4 = 1'b1;
        step();
        clear4 = 1'b0;
        chk("clr_cnt", 32'(cnt4), 32'd0);
        chk("clr_mis", 32'(mis4), 32'd0);
        chk("clr_err", 32'(err4), 32'd0);
        chk("clr_lane", 32'(lane4), 32'd0);
        chk("clr_instr", ins4, 32'd0);
        chk("clr_mask", 32'(msk4), 32'd0);
        bus.valid_i = 2'b01;
        bus.instr_i = {32'h0, 32'h002081B3};
        step();
        bus.valid_i = 2'b00;
        step();
        chk("post_clr_cnt", 32'(cnt4), 32'd1);
        chk("post_clr_mis", 32'(mis4), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
